rv_regs_sb: RTL
===============

Name: rv_regs_sb

Overview:
- Parametrised integer register file with a built-in scoreboard.
- Generalises the two-read/one-write RV32 register file to N read ports, configurable width and depth, per-port read enable (stall hold), and optional write-to-read bypass.
- The scoreboard tracks registers with an in-flight producer, so the issue stage can detect RAW hazards from the registered busy flags.
- Sits between decode/issue (reads, allocations) and writeback (writes).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, 2..64.
- RPORTS, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to that port; 0 = the port returns the old value.
- AW, $clog2(NREGS), register address width; derived, not overridden.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rs  in  RPORTS*AW  packed read addresses; port p occupies [p*AW +: AW].
- i_rs_en  in  RPORTS  per-port read enable; when low, that port's outputs hold.
- i_write  in  1  writeback valid.
- i_rd  in  AW  writeback address.
- i_data  in  XLEN  writeback data.
- i_alloc  in  1  issue of an instruction with a destination; marks i_alloc_rd pending.
- i_alloc_rd  in  AW  destination being allocated.
- o_data  out  RPORTS*XLEN  registered read data, packed like i_rs.
- o_busy  out  RPORTS  registered scoreboard flag for each port's address.
- o_busy_vec  out  NREGS  current scoreboard state, combinational from flops.

Behaviour:
- Reset (i_reset=1 at an edge):
  - all registers set to 0, all busy bits set to 0, o_data=0, o_busy=0.
  - i_write and i_alloc are ignored that cycle.
  - Reset mid-operation discards any pending state; no partial update.
- Register 0 is hardwired:
  - always reads 0 and is never busy.
  - writes and allocs addressed to 0 are dropped.
- Write: when i_write=1 and i_rd!=0, reg[i_rd] <= i_data at the edge.
- Read (per port p, latency 1):
  - if i_rs_en[p]=1 at edge k, o_data[p] after edge k = reg[rs_p] as held before edge k.
  - exception: BYPASS=1 and i_write && i_rd==rs_p && rs_p!=0 in the same cycle → i_data.
  - if i_rs_en[p]=0, o_data[p] and o_busy[p] keep their previous values.
- Scoreboard update at each edge, in this order:
  - a write to rd clears busy[rd];
  - then an alloc to alloc_rd sets busy[alloc_rd].
  - alloc and write to the same register in one cycle → busy stays 1 (the newer producer wins).
- o_busy[p] (when enabled):
  - reflects busy[rs_p] before this cycle's alloc, because the reading instruction is older than the one allocating.
  - includes this cycle's write-clear only when BYPASS=1, consistent with the forwarded data.
  - with BYPASS=0, a same-cycle clear still reports busy=1.
- Alloc to an already-busy register: busy stays 1; no error flag.
- Write to a non-busy register: data is updated; busy stays 0.
- Multiple ports may read the same address; each is resolved independently.
- No combinational path from any input to o_data or o_busy.

Decomposition:
- Package rv_regs_pkg:
  - XLEN_DEFAULT=32, NREGS_DEFAULT=32;
  - typedef reg_addr_t (logic[4:0]), typedef xdata_t (logic[31:0]);
  - constant REG_ZERO=0.
- Sub-module rv_scoreboard:
  - holds the NREGS busy bits;
  - inputs: write/alloc events and read addresses;
  - outputs: per-port busy lookups, with the BYPASS clear applied, and o_busy_vec.
- rv_regs_sb instantiates rv_scoreboard plus the storage array and the per-port read/bypass muxes.

Test Plan:
- Reset then read x1..x31 on both ports → all o_data=0, o_busy=0, o_busy_vec=0.
- Write x5=0xDEADBEEF; next cycle read rs0=5 → o_data[0]=0xDEADBEEF one cycle later. Write x0=0x1234 then read x0 → 0.
- BYPASS=1: write x7=0xA5A5A5A5 and read rs1=7 in the same cycle → o_data[1]=0xA5A5A5A5. BYPASS=0 build, same stimulus → the prior value of x7.
- Alloc x3 at cycle 0; read x3 at cycle 1 → o_busy=1. Write x3=0x55 at cycle 3 with a read of x3 → BYPASS=1 gives o_busy=0, data 0x55. Alloc x3 and write x3 in the same cycle → o_busy_vec[3] stays 1.
- Set o_data[0]=x5 value, then drop i_rs_en[0] for 3 cycles while changing i_rs and writing x5 → o_data[0] and o_busy[0] unchanged. Re-enable → new value appears next cycle.
- Alloc x9 and write x9=0x77, then assert i_reset one cycle with i_write=1 to x9 → x9=0, busy[9]=0, and the write is ignored.

Source files
------------

// File: rtl/rv_regs_pkg.sv
// Shared definitions for the rv_regs_sb register file and its scoreboard.
// Provides default sizing, convenience types for the default RV32
// configuration, and the index of the hardwired-zero register.
package rv_regs_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xdata_t;

    // Architectural register that always reads zero and never goes busy.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/rv_scoreboard.sv
// Busy-bit scoreboard for the register file.
// One busy bit per register, set when an instruction with that destination
// issues (alloc) and cleared when its result is written back.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   write, rd        writeback event (clears busy[rd])
//   alloc, alloc_rd  issue event (sets busy[alloc_rd]; wins over a same-cycle clear)
//   rs               packed read addresses, port p at [p*AW +: AW]
//   rs_busy          combinational busy lookup per port, pre-alloc,
//                    with the same-cycle writeback clear applied when BYPASS=1
//   busy_vec         current busy bits straight from the flops
module rv_scoreboard
    import rv_regs_pkg::*;
#(
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int RPORTS = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [AW-1:0]        rd,
    input  logic                 alloc,
    input  logic [AW-1:0]        alloc_rd,
    input  logic [RPORTS*AW-1:0] rs,
    output logic [RPORTS-1:0]    rs_busy,
    output logic [NREGS-1:0]     busy_vec
);

    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional update, so no path leaves it unassigned (no latch).
        busy_d = busy_q;
        // Clear first, then set: an alloc in the same cycle as the writeback
        // belongs to a newer producer and must leave the register busy.
        if (write && rd != ZERO) begin
            busy_d[rd] = 1'b0;
        end
        if (alloc && alloc_rd != ZERO) begin
            busy_d[alloc_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of process ordering.
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // The reader is older than any instruction allocating this cycle, so the
    // lookup uses busy_q and ignores the alloc.
    for (genvar p = 0; p < RPORTS; p++) begin : g_port
        logic [AW-1:0] addr;
        logic          wb_hit;

        assign addr       = rs[p*AW +: AW];
        assign wb_hit     = (BYPASS != 0) && write && (rd == addr) && (addr != ZERO);
        assign rs_busy[p] = busy_q[addr] & ~wb_hit;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/rv_regs_sb.sv
// Parametrised integer register file with built-in RAW scoreboard.
// N registered read ports with per-port enable (outputs hold while disabled),
// one writeback port with optional same-cycle forwarding, register 0 wired
// to zero.
//
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset
//   i_rs, i_rs_en   packed read addresses and per-port read enables
//   i_write, i_rd, i_data    writeback
//   i_alloc, i_alloc_rd      destination allocation at issue
//   o_data          registered read data, port p at [p*XLEN +: XLEN]
//   o_busy          registered busy flag for each port's address
//   o_busy_vec      current scoreboard bits
module rv_regs_sb
    import rv_regs_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int RPORTS = 2,
    parameter int BYPASS = 1,
    // Derived from NREGS; leave at its default.
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [RPORTS*AW-1:0]   i_rs,
    input  logic [RPORTS-1:0]      i_rs_en,
    input  logic                   i_write,
    input  logic [AW-1:0]          i_rd,
    input  logic [XLEN-1:0]        i_data,
    input  logic                   i_alloc,
    input  logic [AW-1:0]          i_alloc_rd,
    output logic [RPORTS*XLEN-1:0] o_data,
    output logic [RPORTS-1:0]      o_busy,
    output logic [NREGS-1:0]       o_busy_vec
);

    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic [XLEN-1:0]   regs    [NREGS];
    logic [XLEN-1:0]   rd_val  [RPORTS];
    logic [XLEN-1:0]   data_q  [RPORTS];
    logic [RPORTS-1:0] sb_busy;
    logic [RPORTS-1:0] busy_q;

    rv_scoreboard #(
        .NREGS  (NREGS),
        .RPORTS (RPORTS),
        .BYPASS (BYPASS),
        .AW     (AW)
    ) u_scoreboard (
        .clk      (i_clk),
        .reset    (i_reset),
        .write    (i_write),
        .rd       (i_rd),
        .alloc    (i_alloc),
        .alloc_rd (i_alloc_rd),
        .rs       (i_rs),
        .rs_busy  (sb_busy),
        .busy_vec (o_busy_vec)
    );

    // NOTE: the storage array is cleared on reset because reset must leave
    // every architectural register at zero; this makes it a flop array
    // rather than a RAM macro.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (i_write && i_rd != ZERO) begin
            regs[i_rd] <= i_data;
        end
    end

    for (genvar p = 0; p < RPORTS; p++) begin : g_read
        logic [AW-1:0] addr;
        logic          wb_hit;

        assign addr   = i_rs[p*AW +: AW];
        assign wb_hit = (BYPASS != 0) && i_write && (i_rd == addr) && (addr != ZERO);
        // Register 0 is forced to zero on the read side as well, so it reads
        // zero even before the first reset.
        assign rd_val[p] = wb_hit         ? i_data :
                           (addr == ZERO) ? '0     : regs[addr];

        assign o_data[p*XLEN +: XLEN] = data_q[p];
    end

    // Output registers: a disabled port holds both its data and busy flag so
    // a stalled issue stage sees a stable operand.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int p = 0; p < RPORTS; p++) begin
                data_q[p] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int p = 0; p < RPORTS; p++) begin
                if (i_rs_en[p]) begin
                    data_q[p] <= rd_val[p];
                    busy_q[p] <= sb_busy[p];
                end
            end
        end
    end

    assign o_busy = busy_q;

endmodule
